// File: rtl/attn_token_scheduler_if.sv
// attn_token_scheduler_if: handshake and status bundle between the token scheduler and its host/engines
interface attn_token_scheduler_if #(parameter int SEQ_LEN = 64);
  localparam int TW = $clog2(SEQ_LEN);
  logic start;
  logic abort;
  logic [TW:0] num_tokens;
  logic qkv_start;
  logic qk_start;
  logic softmax_start;
  logic attn_start;
  logic qkv_done;
  logic qk_done;
  logic softmax_done;
  logic attn_done;
  logic kv_write_en;
  logic [TW-1:0] kv_write_addr;
  logic [TW-1:0] token_idx;
  logic busy;
  logic done;
  logic error;
  logic [2:0] fsm_state;
  modport slave (
    input start, abort, num_tokens, qkv_done, qk_done, softmax_done, attn_done,
    output qkv_start, qk_start, softmax_start, attn_start, kv_write_en, kv_write_addr,
    output token_idx, busy, done, error, fsm_state
  );
  modport master (
    output start, abort, num_tokens, qkv_done, qk_done, softmax_done, attn_done,
    input qkv_start, qk_start, softmax_start, attn_start, kv_write_en, kv_write_addr,
    input token_idx, busy, done, error, fsm_state
  );
endinterface

// File: rtl/attn_token_scheduler.sv
// attn_token_scheduler: steps each token through QKV, KV write, QK, softmax and attention stages with a watchdog
module attn_token_scheduler #(
  parameter int SEQ_LEN        = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic clk,
  input logic rst_n,
  attn_token_scheduler_if.slave bus
);
  localparam int TW = $clog2(SEQ_LEN);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW:0] N_MAX = (TW+1)'(SEQ_LEN);
  typedef enum logic [2:0] {IDLE, QKV, QK, SMAX, ATTN, NEXT, DONE, ERR} state_t;
  state_t state, nxt;
  logic [TW:0] n, n_nxt;
  logic [TW-1:0] idx, idx_nxt;
  logic [WW-1:0] wd;
  logic first, stage, acc, tmo;
  // the start registers double as the "first cycle in stage" marker, so a done on that cycle is ignored
  assign first = bus.qkv_start | bus.qk_start | bus.softmax_start | bus.attn_start;
  assign stage = state inside {QKV, QK, SMAX, ATTN};
  assign acc = !first && ((state == QKV && bus.qkv_done) || (state == QK && bus.qk_done) ||
                          (state == SMAX && bus.softmax_done) || (state == ATTN && bus.attn_done));
  assign tmo = stage && wd == WW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    nxt = state;
    n_nxt = n;
    idx_nxt = idx;
    case (state)
      IDLE: if (bus.start) begin
        n_nxt = bus.num_tokens > N_MAX ? N_MAX : bus.num_tokens;
        idx_nxt = '0;
        nxt = n_nxt == '0 ? DONE : QKV;
      end
      QKV:  nxt = acc ? QK : tmo ? ERR : QKV;
      QK:   nxt = acc ? SMAX : tmo ? ERR : QK;
      SMAX: nxt = acc ? ATTN : tmo ? ERR : SMAX;
      ATTN: nxt = acc ? NEXT : tmo ? ERR : ATTN;
      NEXT: if ({1'b0, idx} == n - 1'b1) nxt = DONE;
      else begin
        idx_nxt = idx + 1'b1;
        nxt = QKV;
      end
      DONE: nxt = IDLE;
      default: nxt = ERR;
    endcase
    if (bus.abort) begin
      nxt = IDLE;
      n_nxt = n;
      idx_nxt = idx;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      n <= '0;
      idx <= '0;
      wd <= '0;
      bus.qkv_start <= 1'b0;
      bus.qk_start <= 1'b0;
      bus.softmax_start <= 1'b0;
      bus.attn_start <= 1'b0;
      bus.kv_write_en <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.error <= 1'b0;
    end else begin
      state <= nxt;
      n <= n_nxt;
      idx <= idx_nxt;
      wd <= (stage && nxt == state) ? wd + 1'b1 : '0;
      bus.qkv_start <= nxt == QKV && state != QKV;
      bus.qk_start <= nxt == QK && state != QK;
      bus.softmax_start <= nxt == SMAX && state != SMAX;
      bus.attn_start <= nxt == ATTN && state != ATTN;
      bus.kv_write_en <= state == QKV && nxt == QK;
      bus.busy <= nxt != IDLE;
      bus.done <= nxt == DONE;
      bus.error <= nxt == ERR;
    end
  end
  assign bus.token_idx = idx;
  assign bus.kv_write_addr = idx;
  assign bus.fsm_state = state;
endmodule
